// File: rtl/pm_loader_pkg.sv
// Shared definitions for the program-memory loader: CPU modes, default widths, FSM states.
package pm_loader_pkg;

    localparam int unsigned PM_ADDRESS_WIDTH    = 4;
    localparam int unsigned PM_INSTR_WORD_WIDTH = 8;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_PROG_PM = 2'd1;
    localparam logic [1:0] MODE_PROG_DM = 2'd2;
    localparam logic [1:0] MODE_HALT    = 2'd3;

    typedef enum logic [2:0] {
        PML_IDLE   = 3'd0,
        PML_SHIFT  = 3'd1,
        PML_PARITY = 3'd2,
        PML_WRITE  = 3'd3,
        PML_DONE   = 3'd4
    } pml_state_e;

endpackage

// File: rtl/pm_word_shifter.sv
// Serial-in/parallel-out word register, MSB first, with a bit counter that
// flags the bit completing a word.
module pm_word_shifter
    import pm_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PM_INSTR_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  shift_en,
    input  logic                  bit_in,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  full
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    logic [CNT_W-1:0] cnt;

    // High while the bit being shifted in this cycle completes the word.
    assign full = shift_en && (cnt == CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            word_out <= '0;
        end else if (clr) begin
            cnt      <= '0;
            word_out <= '0;
        end else if (shift_en) begin
            word_out <= {word_out[DATA_WIDTH-2:0], bit_in};
            cnt      <= full ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pm_loader.sv
// Loads a bit-serial program image into PM while mode is PROG_PM.
// Optional per-word even parity bit enabled by defining PM_LOADER_PARITY_EN.
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = PM_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = PM_INSTR_WORD_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic [ADDRESS_WIDTH:0]   prog_len,
    input  logic                     ser_valid,
    input  logic                     ser_bit,
    output logic                     ser_ready,
    output logic                     pm_we,
    output logic [ADDRESS_WIDTH-1:0] pm_addr,
    output logic [DATA_WIDTH-1:0]    pm_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [ADDRESS_WIDTH:0]   words_written
);

    localparam int unsigned LW = ADDRESS_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH = LW'(1) << ADDRESS_WIDTH;

    pml_state_e state, state_d;

    logic                     prog;
    logic                     prog_q;
    logic                     entry;
    logic [LW-1:0]            len_q, len_d, len_clamp;
    logic [ADDRESS_WIDTH-1:0] addr_d;
    logic [LW-1:0]            ww_d;
    logic                     err_d;
    logic                     clr;
    logic                     shift_en;
    logic                     full;
    logic [DATA_WIDTH-1:0]    word;

    assign prog      = (mode == MODE_PROG_PM);
    assign entry     = prog && !prog_q;
    assign len_clamp = (prog_len > DEPTH) ? DEPTH : prog_len;
    assign pm_wdata  = word;

    pm_word_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .shift_en (shift_en),
        .bit_in   (ser_bit),
        .word_out (word),
        .full     (full)
    );

    // Next state and next register values; leaving PROG mid-load aborts.
    always_comb begin
        state_d  = state;
        len_d    = len_q;
        addr_d   = pm_addr;
        ww_d     = words_written;
        err_d    = err;
        clr      = 1'b0;
        shift_en = 1'b0;
        case (state)
            PML_IDLE: begin
                if (entry) begin
                    len_d   = len_clamp;
                    addr_d  = '0;
                    ww_d    = '0;
                    err_d   = 1'b0;
                    clr     = 1'b1;
                    state_d = (len_clamp == '0) ? PML_DONE : PML_SHIFT;
                end
            end
            PML_SHIFT: begin
                if (!prog) begin
                    err_d   = 1'b1;
                    clr     = 1'b1;
                    state_d = PML_IDLE;
                end else if (ser_valid) begin
                    shift_en = 1'b1;
`ifdef PM_LOADER_PARITY_EN
                    if (full) state_d = PML_PARITY;
`else
                    if (full) state_d = PML_WRITE;
`endif
                end
            end
`ifdef PM_LOADER_PARITY_EN
            PML_PARITY: begin
                if (!prog) begin
                    err_d   = 1'b1;
                    clr     = 1'b1;
                    state_d = PML_IDLE;
                end else if (ser_valid) begin
                    if (ser_bit == ^word) begin
                        state_d = PML_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        clr     = 1'b1;
                        state_d = PML_IDLE;
                    end
                end
            end
`endif
            PML_WRITE: begin
                // The strobe for this word is already on the bus, so it is counted.
                ww_d = words_written + LW'(1);
                if (!prog) begin
                    err_d   = 1'b1;
                    state_d = PML_IDLE;
                end else if (ww_d == len_q) begin
                    state_d = PML_DONE;
                end else begin
                    addr_d  = pm_addr + ADDRESS_WIDTH'(1);
                    state_d = PML_SHIFT;
                end
            end
            PML_DONE: begin
                if (!prog) state_d = PML_IDLE;
            end
            default: state_d = PML_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= PML_IDLE;
            prog_q        <= 1'b1;
            len_q         <= '0;
            pm_addr       <= '0;
            words_written <= '0;
            err           <= 1'b0;
            pm_we         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ser_ready     <= 1'b0;
        end else begin
            state         <= state_d;
            prog_q        <= prog;
            len_q         <= len_d;
            pm_addr       <= addr_d;
            words_written <= ww_d;
            err           <= err_d;
            pm_we         <= (state_d == PML_WRITE);
            busy          <= (state_d == PML_SHIFT) || (state_d == PML_PARITY) ||
                             (state_d == PML_WRITE);
            done          <= (state_d == PML_DONE);
            ser_ready     <= (state_d == PML_SHIFT) || (state_d == PML_PARITY);
        end
    end

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader (AW=4, DW=8) with a write scoreboard.
module tb_pm_loader;
    import pm_loader_pkg::*;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    mode = MODE_RUN;
    logic [AW:0]   prog_len = '0;
    logic          ser_valid = 1'b0;
    logic          ser_bit = 1'b0;
    logic          ser_ready;
    logic          pm_we;
    logic [AW-1:0] pm_addr;
    logic [DW-1:0] pm_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_written;

    always #5 clk = ~clk;

    pm_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .prog_len      (prog_len),
        .ser_valid     (ser_valid),
        .ser_bit       (ser_bit),
        .ser_ready     (ser_ready),
        .pm_we         (pm_we),
        .pm_addr       (pm_addr),
        .pm_wdata      (pm_wdata),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];

    // Scoreboard: every PM write must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (pm_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", pm_addr, pm_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(pm_addr), 32'(e.addr));
                chk("wr_data", 32'(pm_wdata), 32'(e.data));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        int   tries = 0;
        logic r;
        do begin
            @(negedge clk);
            ser_valid = 1'b1;
            ser_bit   = b;
            r         = ser_ready;
            @(posedge clk);
            tries++;
        end while (!r && tries < 40);
        if (!r) chk("ready_timeout", 32'(r), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            ser_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int gap);
        for (int i = DW - 1; i >= 0; i--) begin
            send_bit(w[i]);
            if (i > 0 && gap > 0) idle_cycles(gap);
        end
`ifdef PM_LOADER_PARITY_EN
        if (gap > 0) idle_cycles(gap);
        send_bit(^w);
`endif
    endtask

    // The write strobe must appear in the cycle right after the last accepted bit.
    task automatic end_word();
        @(negedge clk);
        ser_valid = 1'b0;
        chk("we_latency", 32'(pm_we), 32'd1);
    endtask

    task automatic enter(input int len);
        @(negedge clk);
        mode      = MODE_PROG_PM;
        prog_len  = (AW + 1)'(len);
        ser_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic leave();
        @(negedge clk);
        mode      = MODE_RUN;
        ser_valid = 1'b0;
        @(posedge clk);
    endtask

    function automatic logic [DW-1:0] word_of(input logic [23:0] dat, input int i);
        if (i < 3) return dat[23 - 8 * i -: 8];
        return 8'(i * 17 + 3);
    endfunction

    typedef struct {
        int          len;
        int          nsend;
        int          gap;
        logic [23:0] dat;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int expw;
        logic [DW-1:0] d;

        vecs[0] = '{3, 3, 0, 24'hA53CFF};
        vecs[1] = '{20, 17, 0, 24'h123456};
        vecs[2] = '{16, 16, 2, 24'h0F1E2D};
        vecs[3] = '{1, 1, 2, 24'h5A0000};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ser_ready", 32'(ser_ready), 32'd0);
        chk("rst_pm_we", 32'(pm_we), 32'd0);
        chk("rst_pm_addr", 32'(pm_addr), 32'd0);
        chk("rst_pm_wdata", 32'(pm_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // Table-driven loads
        for (int v = 0; v < 4; v++) begin
            expw = (vecs[v].len > 16) ? 16 : vecs[v].len;
            enter(vecs[v].len);
            @(negedge clk);
            chk("entry_busy", 32'(busy), 32'd1);
            chk("entry_err", 32'(err), 32'd0);
            for (int w = 0; w < expw; w++) begin
                d = word_of(vecs[v].dat, w);
                exp_q.push_back('{addr: AW'(w), data: d});
                send_word(d, vecs[v].gap);
                end_word();
            end
            @(negedge clk);
            chk("done_after_last", 32'(done), 32'd1);
            chk("words_after_last", 32'(words_written), 32'(expw));
            chk("busy_after_last", 32'(busy), 32'd0);
            for (int w = expw; w < vecs[v].nsend; w++) begin
                d = word_of(vecs[v].dat, w);
                for (int i = DW - 1; i >= 0; i--) begin
                    @(negedge clk);
                    ser_valid = 1'b1;
                    ser_bit   = d[i];
                    @(posedge clk);
                end
                @(negedge clk);
                ser_valid = 1'b0;
                chk("extra_bits_done", 32'(done), 32'd1);
                chk("extra_bits_words", 32'(words_written), 32'(expw));
            end
            leave();
            @(negedge clk);
            chk("done_clear_on_exit", 32'(done), 32'd0);
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
        end

        // prog_len = 0: done one cycle after entry, no writes
        enter(0);
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_ready", 32'(ser_ready), 32'd0);
        idle_cycles(3);
        leave();

        // Abort mid-word: partial word discarded, committed count kept
        enter(2);
        exp_q.push_back('{addr: AW'(0), data: 8'h11});
        send_word(8'h11, 0);
        end_word();
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        @(negedge clk);
        ser_valid = 1'b0;
        mode      = MODE_RUN;
        @(posedge clk);
        @(negedge clk);
        chk("abort_err", 32'(err), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(pm_we), 32'd0);
        chk("abort_words", 32'(words_written), 32'd1);
        idle_cycles(4);
        chk("err_sticky", 32'(err), 32'd1);

        // Re-entry clears err; async reset mid-load with mode held
        enter(2);
        @(negedge clk);
        chk("reentry_err_clear", 32'(err), 32'd0);
        exp_q.push_back('{addr: AW'(0), data: 8'h77});
        send_word(8'h77, 0);
        end_word();
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        @(negedge clk);
        ser_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_words", 32'(words_written), 32'd0);
        chk("arst_addr", 32'(pm_addr), 32'd0);
        chk("arst_ready", 32'(ser_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);
        @(negedge clk);
        chk("no_restart_busy", 32'(busy), 32'd0);
        chk("no_restart_ready", 32'(ser_ready), 32'd0);
        leave();

`ifdef PM_LOADER_PARITY_EN
        // Bad parity: error and no write; good parity afterwards writes
        enter(1);
        for (int i = 7; i >= 0; i--) send_bit(i == 0);
        send_bit(1'b0);
        @(negedge clk);
        ser_valid = 1'b0;
        chk("parity_bad_err", 32'(err), 32'd1);
        chk("parity_bad_we", 32'(pm_we), 32'd0);
        chk("parity_bad_busy", 32'(busy), 32'd0);
        leave();
        enter(1);
        exp_q.push_back('{addr: AW'(0), data: 8'h01});
        send_word(8'h01, 0);
        end_word();
        @(negedge clk);
        chk("parity_ok_done", 32'(done), 32'd1);
        chk("parity_ok_err", 32'(err), 32'd0);
        leave();
`endif

        idle_cycles(5);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
